branch_target_table: RTL and testbench

//  Writable, registered successor to the fixed branch-target LUT. Holds DEPTH entries,

---
 rtl/branch_target_table.sv | 143 ++++++++++++++
 tb/tb_branch_target_table.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/branch_target_table.sv
// branch_target_table
//   Writable branch-target table between decode and the PC register. Each of
//   DEPTH entries holds an absolute target or a PC-relative offset, loaded at
//   runtime through the write port. A lookup issued at cycle N resolves at N+1.
//   After reset or flush a clear sweep invalidates one entry per cycle. While
//   the sweep runs, writes are dropped and lookups miss.
//
// Ports
//   Clk           clock, all state updates on posedge
//   Reset         synchronous active-high reset, wins over every other input
//   flush         restart the clear sweep at index 0
//   wr_en/wr_addr/wr_data/wr_rel   entry write (data is an offset when wr_rel=1)
//   branch/addr/pc                 lookup request, index and current PC
//   target        resolved target (registered), 0 unless target_valid
//   target_valid  previous-cycle lookup hit
//   miss          previous-cycle lookup found no valid entry
//   busy          clear sweep in progress
//
// state | meaning
// CLEAR | sweeping entries invalid, one per cycle; writes dropped, lookups miss
// READY | normal operation; writes accepted, lookups resolve
module branch_target_table #(
  parameter int D      = 10,
  parameter int A      = 8,
  parameter int DEPTH  = 16,
  parameter int REL_EN = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         wr_rel,
  input  logic         branch,
  input  logic [A-1:0] addr,
  input  logic [D-1:0] pc,
  output logic [D-1:0] target,
  output logic         target_valid,
  output logic         miss,
  output logic         busy
);

  localparam int   IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic REL_EN_B = (REL_EN != 0);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state;
  logic [IW-1:0]   sweep_idx;

  logic            ent_valid [DEPTH];
  logic            ent_rel   [DEPTH];
  logic [D-1:0]    ent_data  [DEPTH];

  logic            wr_inrange;
  logic            lk_inrange;
  logic            wr_ok;
  logic            fwd;
  logic            lk_valid;
  logic            lk_rel;
  logic [D-1:0]    lk_data;
  logic            lk_hit;
  logic [D-1:0]    rel_sum;
  logic [IW-1:0]   widx;
  logic [IW-1:0]   lidx;

  // The range check uses the full index width.
  // The array index uses only the low bits, which the range check already protects.
  always_comb begin
    wr_inrange = 32'(wr_addr) < DEPTH;
    lk_inrange = 32'(addr) < DEPTH;
    widx       = wr_addr[IW-1:0];
    lidx       = addr[IW-1:0];
    wr_ok      = (state == READY) && wr_en && wr_inrange;
    // A write to the same index in the same cycle is forwarded into the lookup.
    fwd        = wr_ok && (wr_addr == addr);
    lk_valid   = 1'b0;
    lk_rel     = 1'b0;
    lk_data    = '0;
    if (fwd) begin
      lk_valid = 1'b1;
      lk_rel   = wr_rel & REL_EN_B;
      lk_data  = wr_data;
    end else if (lk_inrange) begin
      lk_valid = ent_valid[lidx];
      lk_rel   = ent_rel[lidx];
      lk_data  = ent_data[lidx];
    end
    lk_hit  = (state == READY) && lk_inrange && lk_valid;
    rel_sum = pc + lk_data;  // carry discarded: silent wrap
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= CLEAR;
      sweep_idx    <= '0;
      busy         <= 1'b1;
      target       <= '0;
      target_valid <= 1'b0;
      miss         <= 1'b0;
    end else begin
      target       <= '0;
      target_valid <= 1'b0;
      miss         <= 1'b0;
      // The lookup sees contents from before any flush in the same cycle.
      if (branch) begin
        if (lk_hit) begin
          target_valid <= 1'b1;
          target       <= lk_rel ? rel_sum : lk_data;
        end else begin
          miss <= 1'b1;
        end
      end

      if (wr_ok) begin
        ent_valid[widx] <= 1'b1;
        ent_rel[widx]   <= wr_rel & REL_EN_B;
        ent_data[widx]  <= wr_data;
      end

      case (state)
        CLEAR: begin
          ent_valid[sweep_idx] <= 1'b0;
          if (sweep_idx == IW'(DEPTH - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        default: ;
      endcase

      if (flush) begin
        state     <= CLEAR;
        sweep_idx <= '0;
        busy      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_table.sv
module tb_branch_target_table;
  localparam int D     = 10;
  localparam int A     = 8;
  localparam int DEPTH = 16;

  logic         Clk = 1'b0;
  logic         Reset, flush, wr_en, wr_rel, branch;
  logic [A-1:0] wr_addr, addr;
  logic [D-1:0] wr_data, pc;
  logic [D-1:0] target;
  logic         target_valid, miss, busy;

  branch_target_table #(.D(D), .A(A), .DEPTH(DEPTH), .REL_EN(1)) dut (
    .Clk(Clk), .Reset(Reset), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_rel(wr_rel), .branch(branch), .addr(addr), .pc(pc),
    .target(target), .target_valid(target_valid), .miss(miss), .busy(busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [D-1:0] t;
    logic         v;
    logic         m;
    logic         b;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: a table of entries and a count of remaining busy cycles.
  // A reset or flush wipes the table at once, because nothing can observe the entries until the sweep ends.
  bit           mv [DEPTH];
  bit           mr [DEPTH];
  int           md [DEPTH];
  int           clear_left = 0;

  task automatic step(input bit rst, input bit fl, input bit we, input int wa,
                      input int wd_in, input bit wrel, input bit br, input int ad,
                      input int p);
    exp_t e;
    int   wd;
    int   dd;
    bit   rr;
    bit   hit;
    wd = wd_in % (1 << D);
    Reset = rst; flush = fl; wr_en = we; wr_addr = A'(wa); wr_data = D'(wd);
    wr_rel = wrel; branch = br; addr = A'(ad); pc = D'(p);
    e = '0;
    hit = 0; dd = 0; rr = 0;
    if (!rst && br) begin
      if (clear_left == 0 && ad < DEPTH) begin
        if (we && wa == ad) begin
          hit = 1; dd = wd; rr = wrel;
        end else if (mv[ad]) begin
          hit = 1; dd = md[ad]; rr = mr[ad];
        end
      end
      if (hit) begin
        e.t = rr ? D'((p + dd) % (1 << D)) : D'(dd);
        e.v = 1'b1;
      end else begin
        e.m = 1'b1;
      end
    end
    if (!rst && clear_left == 0 && we && wa < DEPTH) begin
      mv[wa] = 1; mr[wa] = wrel; md[wa] = wd;
    end
    if (rst || fl) begin
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mv[i] = 0;
    end else if (clear_left > 0) begin
      clear_left--;
    end
    e.b = (clear_left > 0);
    @(posedge Clk);
    q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int wa, input int wd, input bit wrel);
    step(0, 0, 1, wa, wd, wrel, 0, 0, 0);
  endtask

  task automatic lk(input int ad, input int p);
    step(0, 0, 0, 0, 0, 0, 1, ad, p);
  endtask

  // Monitor: every registered output sample is paired with the oldest expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({target, target_valid, miss, busy} !== e) begin
        failures++;
        $display("FAIL out t=%0t got target=%0d valid=%b miss=%b busy=%b want target=%0d valid=%b miss=%b busy=%b",
                 $time, target, target_valid, miss, busy, e.t, e.v, e.m, e.b);
      end
    end
  end

  initial begin
    Reset = 1; flush = 0; wr_en = 0; wr_rel = 0; branch = 0;
    wr_addr = '0; addr = '0; wr_data = '0; pc = '0;
    #1;
    // Reset and sweep; lookup during the sweep misses.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    lk(2, 0);
    idle(11);
    wr(6, 123, 0);       // final sweep cycle: dropped
    idle(1);
    lk(6, 0);            // the dropped write must still miss
    // Absolute entries, back-to-back lookups.
    wr(1, 26, 0);
    wr(5, 270, 0);
    lk(1, 0);
    lk(5, 0);
    // Relative entries, including wrap.
    wr(3, 'h3FC, 1);
    wr(4, 10, 1);
    lk(3, 100);
    lk(4, 1020);
    // Misses: unwritten index and an out-of-range index; the out-of-range write is dropped.
    lk(7, 0);
    lk(20, 0);
    wr(20, 99, 0);
    lk(4, 1020);
    lk(20, 0);
    // Same-cycle write and lookup forwarding.
    step(0, 0, 1, 9, 356, 0, 1, 9, 0);
    step(0, 0, 1, 5, 77, 1, 1, 5, 1000);
    lk(9, 0);
    // A flush in the same cycle as a lookup still uses the old contents.
    step(0, 1, 0, 0, 0, 0, 1, 1, 0);
    lk(1, 0);
    idle(14);
    lk(1, 0);
    lk(1, 0);
    // Reset in the middle of a sweep restarts it.
    wr(2, 500, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(7);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(16);
    lk(2, 0);
    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 300) == 0, ($urandom % 80) == 0, $urandom % 2,
           $urandom_range(0, 20), $urandom % 1024, $urandom % 2,
           ($urandom % 4) != 0, $urandom_range(0, 20), $urandom % 1024);
    end
    idle(2);
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
